// File: rtl/l1_cache_ctrl_p0.sv
// Private L1 controller for core 0: direct-mapped MSI lines with one
// word each, GetS/GetM/PutM to the home directory, INV/DOWNGRADE acks.
module l1_cache_ctrl_p0 #(
  parameter int LINES  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_valid,
  input  logic              cpu_op,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              dir_req_valid,
  output logic [1:0]        dir_req_type,
  output logic [ADDR_W-1:0] dir_req_addr,
  output logic [DATA_W-1:0] dir_req_data,
  input  logic              dir_req_ready,
  input  logic              dir_resp_valid,
  input  logic [DATA_W-1:0] dir_resp_data,
  input  logic              dir_cmd_valid,
  input  logic              dir_cmd_type,
  input  logic [ADDR_W-1:0] dir_cmd_addr,
  output logic              dir_cmd_ready,
  output logic              ack_valid,
  output logic              ack_dirty,
  output logic [DATA_W-1:0] ack_data
);
  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_W - IW;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_REQ, S_WAIT} st_e;
  typedef enum logic [1:0] {L_I, L_S, L_M} ln_e;

  st_e state_q, state_d;
  ln_e         ln_q   [LINES];
  logic [TW-1:0]     tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  logic              op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              done_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ack_v_q;
  logic              ack_d_q;
  logic [DATA_W-1:0] ack_dat_q;

  logic [IW-1:0] c_idx, l_idx, m_idx;
  logic [TW-1:0] c_tag, l_tag, m_tag;
  logic          c_hit, m_hit;
  logic          accept, cmd_acc, fill;

  assign c_idx = cpu_addr[IW-1:0];
  assign c_tag = cpu_addr[ADDR_W-1:IW];
  assign l_idx = addr_q[IW-1:0];
  assign l_tag = addr_q[ADDR_W-1:IW];
  assign m_idx = dir_cmd_addr[IW-1:0];
  assign m_tag = dir_cmd_addr[ADDR_W-1:IW];

  assign c_hit = (ln_q[c_idx] != L_I) && (tag_q[c_idx] == c_tag);
  assign m_hit = (ln_q[m_idx] != L_I) && (tag_q[m_idx] == m_tag);

  assign accept  = cpu_valid && cpu_ready;
  assign cmd_acc = dir_cmd_valid && dir_cmd_ready;
  assign fill    = (state_q == S_WAIT) && dir_resp_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        if (c_hit && (!cpu_op || ln_q[c_idx] == L_M))
          state_d = S_IDLE;
        else if (!c_hit && ln_q[c_idx] == L_M)
          state_d = S_WB;
        else
          state_d = S_REQ;
      end
      S_WB:   if (dir_req_ready) state_d = S_REQ;
      S_REQ:  if (dir_req_ready) state_d = S_WAIT;
      S_WAIT: if (dir_resp_valid) state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dir_req_valid = 1'b0;
    dir_req_type  = 2'd0;
    dir_req_addr  = '0;
    dir_req_data  = '0;
    unique case (state_q)
      S_WB: begin
        dir_req_valid = 1'b1;
        dir_req_type  = 2'd2;
        dir_req_addr  = {tag_q[l_idx], l_idx};
        dir_req_data  = data_q[l_idx];
      end
      S_REQ: begin
        dir_req_valid = 1'b1;
        dir_req_type  = {1'b0, op_q};
        dir_req_addr  = addr_q;
      end
      default: ;
    endcase
    cpu_ready     = (state_q == S_IDLE) && !dir_cmd_valid;
    dir_cmd_ready = (state_q == S_IDLE) || (state_q == S_WAIT);
  end

  // Command effects are written before the fill so a same-cycle fill wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        ln_q[i]   <= L_I;
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      op_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      ack_v_q   <= 1'b0;
      ack_d_q   <= 1'b0;
      ack_dat_q <= '0;
    end else begin
      done_q    <= 1'b0;
      ack_v_q   <= 1'b0;
      ack_d_q   <= 1'b0;
      ack_dat_q <= '0;
      if (accept) begin
        op_q    <= cpu_op;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        if (c_hit && !cpu_op) begin
          done_q  <= 1'b1;
          rdata_q <= data_q[c_idx];
        end else if (c_hit && ln_q[c_idx] == L_M) begin
          done_q        <= 1'b1;
          data_q[c_idx] <= cpu_wdata;
        end
      end
      if (state_q == S_WB && dir_req_ready) ln_q[l_idx] <= L_I;
      if (cmd_acc) begin
        ack_v_q <= 1'b1;
        if (m_hit && ln_q[m_idx] == L_M) begin
          ack_d_q   <= 1'b1;
          ack_dat_q <= data_q[m_idx];
        end
        if (m_hit) begin
          if (!dir_cmd_type)             ln_q[m_idx] <= L_I;
          else if (ln_q[m_idx] == L_M)   ln_q[m_idx] <= L_S;
        end
      end
      if (fill) begin
        tag_q[l_idx] <= l_tag;
        done_q       <= 1'b1;
        if (op_q) begin
          data_q[l_idx] <= wdata_q;
          ln_q[l_idx]   <= L_M;
        end else begin
          data_q[l_idx] <= dir_resp_data;
          ln_q[l_idx]   <= L_S;
          rdata_q       <= dir_resp_data;
        end
      end
    end
  end

  assign cpu_done  = done_q;
  assign cpu_rdata = rdata_q;
  assign ack_valid = ack_v_q;
  assign ack_dirty = ack_d_q;
  assign ack_data  = ack_dat_q;

endmodule

// File: tb/tb_l1_cache_ctrl_p0.sv
// Directed bench for l1_cache_ctrl_p0 with scoreboard queues for
// CPU completions, directory requests and command acks.
module tb_l1_cache_ctrl_p0;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_valid = 1'b0, cpu_op = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic       cpu_ready, cpu_done;
  logic [7:0] cpu_rdata;
  logic       dir_req_valid;
  logic [1:0] dir_req_type;
  logic [7:0] dir_req_addr, dir_req_data;
  logic       dir_req_ready = 1'b1;
  logic       dir_resp_valid = 1'b0;
  logic [7:0] dir_resp_data = '0;
  logic       dir_cmd_valid = 1'b0, dir_cmd_type = 1'b0;
  logic [7:0] dir_cmd_addr = '0;
  logic       dir_cmd_ready, ack_valid, ack_dirty;
  logic [7:0] ack_data;

  int checks = 0;
  int errors = 0;

  logic [8:0]  exp_cpu [$];
  logic [8:0]  exp_ack [$];
  logic [17:0] exp_req [$];

  l1_cache_ctrl_p0 #(.LINES(4), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_op(cpu_op),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dir_req_valid(dir_req_valid), .dir_req_type(dir_req_type),
    .dir_req_addr(dir_req_addr), .dir_req_data(dir_req_data),
    .dir_req_ready(dir_req_ready),
    .dir_resp_valid(dir_resp_valid), .dir_resp_data(dir_resp_data),
    .dir_cmd_valid(dir_cmd_valid), .dir_cmd_type(dir_cmd_type),
    .dir_cmd_addr(dir_cmd_addr), .dir_cmd_ready(dir_cmd_ready),
    .ack_valid(ack_valid), .ack_dirty(ack_dirty), .ack_data(ack_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cpu(input logic rd, input logic [7:0] d);
    exp_cpu.push_back({rd, d});
  endtask
  task automatic push_req(input logic [1:0] t, input logic [7:0] a,
                          input logic [7:0] d);
    exp_req.push_back({t, a, d});
  endtask
  task automatic push_ack(input logic dirty, input logic [7:0] d);
    exp_ack.push_back({dirty, d});
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_done) begin
        if (exp_cpu.size() == 0) check("cpu_done_unexpected", 1, 0);
        else begin
          logic [8:0] e;
          e = exp_cpu.pop_front();
          if (e[8]) check("cpu_rdata", 32'(cpu_rdata), 32'(e[7:0]));
        end
      end
      if (ack_valid) begin
        if (exp_ack.size() == 0) check("ack_unexpected", 1, 0);
        else begin
          logic [8:0] e;
          e = exp_ack.pop_front();
          check("ack_dirty", 32'(ack_dirty), 32'(e[8]));
          check("ack_data", 32'(ack_data), 32'(e[7:0]));
        end
      end
      if (dir_req_valid && dir_req_ready) begin
        if (exp_req.size() == 0) check("req_unexpected", 1, 0);
        else begin
          logic [17:0] e;
          e = exp_req.pop_front();
          check("req_type", 32'(dir_req_type), 32'(e[17:16]));
          check("req_addr", 32'(dir_req_addr), 32'(e[15:8]));
          if (e[17:16] == 2'd2)
            check("req_data", 32'(dir_req_data), 32'(e[7:0]));
        end
      end
    end
  end

  task automatic cpu_req(input logic op, input logic [7:0] a,
                         input logic [7:0] d);
    bit ok = 0;
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_op = op; cpu_addr = a; cpu_wdata = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cpu_ready) begin ok = 1; break; end
    end
    if (!ok) check("cpu_ready_timeout", 0, 1);
    @(posedge clk); #1;
    cpu_valid = 1'b0;
  endtask

  task automatic wait_fill_hs();
    bit ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (dir_req_valid && dir_req_ready && dir_req_type != 2'd2) begin
        ok = 1; break;
      end
    end
    if (!ok) check("dir_req_timeout", 0, 1);
  endtask

  task automatic respond(input logic [7:0] d);
    wait_fill_hs();
    @(posedge clk); #1;
    dir_resp_valid = 1'b1; dir_resp_data = d;
    @(posedge clk); #1;
    dir_resp_valid = 1'b0;
  endtask

  task automatic dir_cmd(input logic t, input logic [7:0] a);
    bit ok = 0;
    @(posedge clk); #1;
    dir_cmd_valid = 1'b1; dir_cmd_type = t; dir_cmd_addr = a;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (dir_cmd_ready) begin ok = 1; break; end
    end
    if (!ok) check("cmd_ready_timeout", 0, 1);
    @(posedge clk); #1;
    dir_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (exp_cpu.size() == 0 && exp_ack.size() == 0 &&
          exp_req.size() == 0) begin
        ok = 1; break;
      end
    end
    if (!ok) check("drain_timeout", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({cpu_done, dir_req_valid, ack_valid,
                              ack_dirty, dir_req_type}), 0);
    check({tag, "_dat"}, 32'({cpu_rdata, ack_data, dir_req_addr,
                              dir_req_data}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    check("reset_cpu_ready", 32'(cpu_ready), 1);
    reset = 1'b0;

    // cold read miss then hit
    push_req(2'd0, 8'h00, 8'h00);
    push_cpu(1'b1, 8'h3C);
    cpu_req(1'b0, 8'h00, 8'h00);
    respond(8'h3C);
    drain();
    push_cpu(1'b1, 8'h3C);
    cpu_req(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("hit_latency", 32'(cpu_done), 1);
    check("hit_no_req", 32'(dir_req_valid), 0);
    drain();

    // cold write miss, read hit, downgrade
    push_req(2'd1, 8'h05, 8'h00);
    push_cpu(1'b0, 8'h00);
    cpu_req(1'b1, 8'h05, 8'h78);
    respond(8'hAA);
    drain();
    push_cpu(1'b1, 8'h78);
    cpu_req(1'b0, 8'h05, 8'h00);
    @(negedge clk);
    check("whit_read_latency", 32'(cpu_done), 1);
    drain();
    push_ack(1'b1, 8'h78);
    dir_cmd(1'b1, 8'h05);
    drain();
    push_ack(1'b0, 8'h00);
    dir_cmd(1'b1, 8'h05);
    drain();

    // read to S, upgrade, INV, re-miss
    push_req(2'd0, 8'h04, 8'h00);
    push_cpu(1'b1, 8'h55);
    cpu_req(1'b0, 8'h04, 8'h00);
    respond(8'h55);
    drain();
    push_req(2'd1, 8'h04, 8'h00);
    push_cpu(1'b0, 8'h00);
    cpu_req(1'b1, 8'h04, 8'h90);
    respond(8'h11);
    drain();
    push_ack(1'b1, 8'h90);
    dir_cmd(1'b0, 8'h04);
    drain();
    push_req(2'd0, 8'h04, 8'h00);
    push_cpu(1'b1, 8'h66);
    cpu_req(1'b0, 8'h04, 8'h00);
    respond(8'h66);
    drain();

    // dirty victim writeback with a stalled directory
    push_req(2'd1, 8'h05, 8'h00);
    push_cpu(1'b0, 8'h00);
    cpu_req(1'b1, 8'h05, 8'h78);
    respond(8'h00);
    drain();
    dir_req_ready = 1'b0;
    push_req(2'd2, 8'h05, 8'h78);
    push_req(2'd0, 8'h09, 8'h00);
    push_cpu(1'b1, 8'hC3);
    cpu_req(1'b0, 8'h09, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("putm_hold", 32'({dir_req_valid, dir_req_type, dir_req_addr,
                              dir_req_data}),
            32'({1'b1, 2'd2, 8'h05, 8'h78}));
    end
    @(posedge clk); #1;
    dir_req_ready = 1'b1;
    respond(8'hC3);
    drain();

    // command and CPU request in the same cycle
    push_ack(1'b0, 8'h00);
    push_cpu(1'b1, 8'hC3);
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_op = 1'b0; cpu_addr = 8'h09;
    dir_cmd_valid = 1'b1; dir_cmd_type = 1'b0; dir_cmd_addr = 8'h0D;
    @(negedge clk);
    check("prio_cpu_ready", 32'(cpu_ready), 0);
    check("prio_cmd_ready", 32'(dir_cmd_ready), 1);
    @(posedge clk); #1;
    dir_cmd_valid = 1'b0;
    @(negedge clk);
    check("prio_ack_first", 32'({ack_valid, cpu_done}), 32'(2'b10));
    check("prio_cpu_ready2", 32'(cpu_ready), 1);
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    @(negedge clk);
    check("prio_cpu_done", 32'(cpu_done), 1);
    drain();

    // reset while waiting for a fill
    push_req(2'd0, 8'h10, 8'h00);
    cpu_req(1'b0, 8'h10, 8'h00);
    wait_fill_hs();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    push_req(2'd0, 8'h10, 8'h00);
    push_cpu(1'b1, 8'h5A);
    cpu_req(1'b0, 8'h10, 8'h00);
    respond(8'h5A);
    drain();

    // INV and fill together on a pending upgrade
    push_req(2'd1, 8'h10, 8'h00);
    push_cpu(1'b0, 8'h00);
    push_ack(1'b0, 8'h00);
    cpu_req(1'b1, 8'h10, 8'hE1);
    wait_fill_hs();
    @(posedge clk); #1;
    dir_cmd_valid = 1'b1; dir_cmd_type = 1'b0; dir_cmd_addr = 8'h10;
    dir_resp_valid = 1'b1; dir_resp_data = 8'h22;
    @(negedge clk);
    check("wait_cmd_ready", 32'(dir_cmd_ready), 1);
    @(posedge clk); #1;
    dir_cmd_valid = 1'b0;
    dir_resp_valid = 1'b0;
    drain();
    push_ack(1'b1, 8'hE1);
    dir_cmd(1'b1, 8'h10);
    drain();

    check("queues_empty", 32'(exp_cpu.size() + exp_ack.size() +
                             exp_req.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
